// File: rtl/idex_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// idex_pipe_reg_if
//
// Purpose:
//   Bundles the decode-side (D) and execute-side (E) handshake and payload
//   signals of the ID/EX pipeline register, plus the execute-stage flush.
//
// Signals:
//   FlushE                       discard every entry held in the stage
//   ValidD / ReadyD              decode-side valid/ready handshake
//   CtrlD, ALU1CntrlD,
//   ALU2CntrlD, SrcD, SignImmD,
//   RtD, RdD                     decode-side instruction payload
//   ValidE / ReadyE              execute-side valid/ready handshake
//   CtrlE ... RdE                registered execute-side payload
//
// Modports:
//   slave  - the pipeline register itself (consumes D side, produces E side)
//   master - the surrounding environment (decode + execute stages)
// -----------------------------------------------------------------------------
interface idex_pipe_reg_if #(
    parameter int BUS_WIDTH      = 32,
    parameter int NUM_SRC        = 3,
    parameter int ALU_FUNCT_BITS = 3,
    parameter int REG_ADDR_BITS  = 5,
    parameter int CTRL_BITS      = 7
) ();

    logic                            FlushE;

    logic                            ValidD;
    logic                            ReadyD;
    logic [CTRL_BITS-1:0]            CtrlD;
    logic [ALU_FUNCT_BITS-1:0]       ALU1CntrlD;
    logic [ALU_FUNCT_BITS-1:0]       ALU2CntrlD;
    logic [NUM_SRC*BUS_WIDTH-1:0]    SrcD;
    logic [BUS_WIDTH-1:0]            SignImmD;
    logic [REG_ADDR_BITS-1:0]        RtD;
    logic [REG_ADDR_BITS-1:0]        RdD;

    logic                            ValidE;
    logic                            ReadyE;
    logic [CTRL_BITS-1:0]            CtrlE;
    logic [ALU_FUNCT_BITS-1:0]       ALU1CntrlE;
    logic [ALU_FUNCT_BITS-1:0]       ALU2CntrlE;
    logic [NUM_SRC*BUS_WIDTH-1:0]    SrcE;
    logic [BUS_WIDTH-1:0]            SignImmE;
    logic [REG_ADDR_BITS-1:0]        RtE;
    logic [REG_ADDR_BITS-1:0]        RdE;

    modport slave (
        input  FlushE,
        input  ValidD, CtrlD, ALU1CntrlD, ALU2CntrlD, SrcD, SignImmD, RtD, RdD,
        output ReadyD,
        output ValidE, CtrlE, ALU1CntrlE, ALU2CntrlE, SrcE, SignImmE, RtE, RdE,
        input  ReadyE
    );

    modport master (
        output FlushE,
        output ValidD, CtrlD, ALU1CntrlD, ALU2CntrlD, SrcD, SignImmD, RtD, RdD,
        input  ReadyD,
        input  ValidE, CtrlE, ALU1CntrlE, ALU2CntrlE, SrcE, SignImmE, RtE, RdE,
        output ReadyE
    );

endinterface

// File: rtl/idex_pipe_reg.sv
// -----------------------------------------------------------------------------
// idex_pipe_reg
//
// Purpose:
//   ID/EX pipeline register between decode/register-file and the ALU1/ALU2
//   execute stage. A valid/ready handshake on both sides with a 2-entry skid
//   buffer (main + skid) keeps full throughput while ReadyD stays registered.
//   Control fields (CtrlE, ALU1CntrlE, ALU2CntrlE) read zero whenever ValidE
//   is low, so a bubble can never write registers or memory. Operand and
//   register-address fields hold their last value on bubbles.
//
// Ports:
//   CLK        clock, all state updates on posedge
//   RST        synchronous, active-high reset (priority over FlushE)
//   bus        idex_pipe_reg_if.slave: FlushE, D-side handshake/payload,
//              E-side handshake/registered payload
//   StallCntE  (only with IDEX_STALL_CNT_EN) 16-bit saturating count of
//              cycles with ValidE=1 and ReadyE=0; cleared only by RST
//
// Configuration:
//   `define IDEX_STALL_CNT_EN to add the StallCntE port and counter.
// -----------------------------------------------------------------------------
module idex_pipe_reg #(
    parameter int BUS_WIDTH      = 32,
    parameter int NUM_SRC        = 3,
    parameter int ALU_FUNCT_BITS = 3,
    parameter int REG_ADDR_BITS  = 5,
    parameter int CTRL_BITS      = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    idex_pipe_reg_if.slave       bus
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [15:0]          StallCntE
`endif
);

    typedef struct packed {
        logic [CTRL_BITS-1:0]         ctrl;
        logic [ALU_FUNCT_BITS-1:0]    alu1;
        logic [ALU_FUNCT_BITS-1:0]    alu2;
        logic [NUM_SRC*BUS_WIDTH-1:0] src;
        logic [BUS_WIDTH-1:0]         imm;
        logic [REG_ADDR_BITS-1:0]     rt;
        logic [REG_ADDR_BITS-1:0]     rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Zero the control portion of an entry while keeping the datapath fields,
    // so bubbles are harmless without toggling the wide operand buses.
    function automatic entry_t bubble(input entry_t e);
        entry_t r;
        r      = e;
        r.ctrl = '0;
        r.alu1 = '0;
        r.alu2 = '0;
        return r;
    endfunction

    state_t state_q, state_d;
    entry_t main_q,  main_d;
    entry_t skid_q,  skid_d;
    logic   valid_q, valid_d;
    logic   ready_q, ready_d;

    entry_t entry_in;
    logic   accept;
    logic   drain;

    assign entry_in.ctrl = bus.CtrlD;
    assign entry_in.alu1 = bus.ALU1CntrlD;
    assign entry_in.alu2 = bus.ALU2CntrlD;
    assign entry_in.src  = bus.SrcD;
    assign entry_in.imm  = bus.SignImmD;
    assign entry_in.rt   = bus.RtD;
    assign entry_in.rd   = bus.RdD;

    assign accept = bus.ValidD & ready_q;
    assign drain  = valid_q & bus.ReadyE;

    // Next-state and next-entry logic. The main register always feeds the
    // E side; the skid register only fills when the main entry is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = entry_in;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (drain && accept) begin
                    main_d = entry_in;
                end else if (drain) begin
                    main_d  = bubble(main_q);
                    state_d = EMPTY;
                end else if (accept) begin
                    skid_d  = entry_in;
                    state_d = TWO;
                end
            end
            TWO: begin
                // ReadyD is low here, so only a drain can move things.
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                main_d  = bubble(main_q);
                state_d = EMPTY;
            end
        endcase

        // Flush wins over normal operation: a concurrent accept is dropped,
        // a concurrent drain has already been seen downstream.
        if (bus.FlushE) begin
            state_d = EMPTY;
            main_d  = bubble(main_q);
            skid_d  = skid_q;
        end

        // Registered handshake outputs derived from the state being entered.
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ReadyD     = ready_q;
    assign bus.ValidE     = valid_q;
    assign bus.CtrlE      = main_q.ctrl;
    assign bus.ALU1CntrlE = main_q.alu1;
    assign bus.ALU2CntrlE = main_q.alu2;
    assign bus.SrcE       = main_q.src;
    assign bus.SignImmE   = main_q.imm;
    assign bus.RtE        = main_q.rt;
    assign bus.RdE        = main_q.rd;

`ifdef IDEX_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts back-pressure cycles; FlushE deliberately does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !bus.ReadyE) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCntE = stall_cnt_q;
`endif

endmodule
